// File: rtl/lsu_mem_stage.sv
// Load/store stage: one req/gnt/rvalid memory transaction at a time, 3-cycle zero-wait latency, core stalls on busy.
// No response backpressure. Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  state_e      state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] lane;
  logic [31:0] load_ext;

  function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  is_legal = 1'b1;
      3'b001:  is_legal = ~a[0];
      3'b010:  is_legal = (a == 2'b00);
      3'b100:  is_legal = ~we;
      3'b101:  is_legal = ~we & ~a[0];
      default: is_legal = 1'b0;
    endcase
  endfunction

  assign off  = req_q.addr[1:0];
  assign lane = mem_rdata >> {off, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata_rep = req_q.wdata;
    case (req_q.funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{req_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Stores and bus errors report zero data.
  always_comb begin
    load_ext = lane;
    case (req_q.funct3)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: ;
    endcase
    if (req_q.we || mem_err) load_ext = 32'h0;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_REQ) cnt_d = '0;
    else if (state_q == S_WAIT && !mem_rvalid) cnt_d = cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == S_WAIT) && !mem_rvalid && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          state_d = is_legal(req_we, req_funct3, req_addr[1:0]) ? S_REQ : S_ERR;
        end
      end
      S_REQ:  if (mem_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          err_d   = mem_err;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory-side outputs are gated by state so they read zero outside REQ.
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
  assign resp_err   = (state_q == S_ERR) || ((state_q == S_RESP) && err_q);
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req && req_q.we;
  assign mem_addr   = mem_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign mem_be     = mem_req ? be : 4'b0000;
  assign mem_wdata  = mem_req ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases plus randomized transactions against a behavioural reference.
module tb_lsu_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: sizes, alignment and lane extraction computed arithmetically.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input logic merr,
                       output logic legal, output logic [3:0] be, output logic [31:0] mwd,
                       output logic [31:0] erd, output logic eer);
    int unsigned sz, off;
    logic [31:0] mask, v;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = addr % 4;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (addr % sz != 0) legal = 1'b0;
    be   = 4'(((1 << sz) - 1) << off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
    if (sz == 1)      mwd = (wdata & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) mwd = (wdata & 32'hFFFF) * 32'h0001_0001;
    else              mwd = wdata;
    v = (rdata >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    erd = (!legal || we || merr) ? 32'h0 : v;
    eer = !legal || merr;
  endtask

  // rdly < 0: memory never answers.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic merr,
                         input int gdly, input int rdly);
    logic legal, eer, done, granted, saw_req;
    logic [3:0] be;
    logic [31:0] mwd, erd;
    int t, reqc, waitc, exp_lat;
    model(we, f3, addr, wdata, rdata, merr, legal, be, mwd, erd, eer);
    if (legal && rdly < 0) begin
      erd = 32'h0;
      eer = 1'b1;
    end
    exp_lat = !legal ? 1 : (rdly < 0 ? 2 + gdly + TO : 3 + gdly + rdly);
    @(negedge clk);
    chk({tag, "_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    t = 0; reqc = 0; waitc = 0; done = 0; granted = 0; saw_req = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!done && t < 300) begin
      t++;
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
      if (resp_valid) begin
        chk({tag, "_lat"}, t, exp_lat);
        chk({tag, "_rdata"}, resp_rdata, erd);
        chk({tag, "_err"}, resp_err, eer);
        chk({tag, "_ready_resp"}, req_ready, 0);
        chk({tag, "_memreq_seen"}, saw_req, legal);
        done = 1;
      end else begin
        if (mem_req) saw_req = 1;
        if (granted) begin
          if (mem_req) chk({tag, "_req_in_wait"}, mem_req, 0);
          if (rdly >= 0 && waitc == rdly) begin
            mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = merr;
          end
          waitc++;
        end else if (mem_req) begin
          chk({tag, "_we"}, mem_we, we);
          chk({tag, "_addr"}, mem_addr, addr & ~32'h3);
          chk({tag, "_be"}, mem_be, be);
          chk({tag, "_wdata"}, mem_wdata, mwd);
          chk({tag, "_busy"}, busy, 1);
          chk({tag, "_ready_busy"}, req_ready, 0);
          if (reqc == gdly) begin
            mem_gnt = 1'b1;
            granted = 1;
          end
          reqc++;
        end
      end
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    chk({tag, "_ready_after"}, req_ready, 1);
    chk({tag, "_resp_after"}, resp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp", {resp_valid, resp_err}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_mem", {mem_req, mem_we, mem_be}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0);
    run_txn("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 0, 0);
    run_txn("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 0, 0);
    run_txn("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 1'b0, 0, 0);
    run_txn("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 1'b0, 1, 2);
    run_txn("sh",  1'b1, 3'b001, 32'h206, 32'h0000_ABCD, 32'h0, 1'b1, 0, 0);
    run_txn("sb",  1'b1, 3'b000, 32'h301, 32'h1234_56A5, 32'h0, 1'b0, 2, 1);
    run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b0, 0, 0);
    run_txn("f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0);
    run_txn("sbu_ill", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0);
    run_txn("gnt5", 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0, 5, 0);

    // Reset while stalled in REQ, then while in WAIT followed by a stray rvalid.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("rreq_memreq", mem_req, 1);
    rst_n = 1'b0;
    #1 chk("rreq_drop", {mem_req, busy, req_ready}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1 chk("rwait_busy", busy, 1);
    rst_n = 1'b0;
    #1 chk("rwait_drop", {mem_req, busy, req_ready, resp_valid}, 4'b0010);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rwait_noresp", {resp_valid, busy}, 0);
      @(negedge clk);
    end

`ifdef LSU_TIMEOUT_EN
    run_txn("tmo", 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b0, 1, -1);
`else
    run_txn("longwait", 1'b0, 3'b001, 32'h502, 32'h0, 32'h7F00_55AA, 1'b0, 1, 30);
`endif
    mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 chk("late_rvalid", {resp_valid, busy}, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic we;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom);
      run_txn("rnd", we, f3, $urandom, $urandom, $urandom, ($urandom % 8) == 0,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
